cla_seq_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_seq_adder_if.sv | 47 ++++
 rtl/cla4_slice.sv | 26 ++
 rtl/cla_seq_adder.sv | 143 ++++++++++++++
 tb/tb_cla_seq_adder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential CLA adder.
// Optional signed-overflow output is enabled with CLA_SEQ_OVF_EN.
package cla_pkg;

  // Controller state
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Bits handled by one pass of the lookahead slice
  localparam int unsigned NIBBLE = 4;

  // Width of the nibble index for a given operand width; never below 1 bit
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned n;
    n = width / NIBBLE;
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Requester-side bus of the sequential CLA adder (start/done handshake).
// The ovf signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
`ifdef CLA_SEQ_OVF_EN
    input  ovf,
`endif
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
`ifdef CLA_SEQ_OVF_EN
    output ovf,
`endif
    output cout
  );

endinterface

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: per-bit carries plus group
// generate/propagate so slices can also be cascaded in a tree.
module cla4_slice (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       cin_i,
  output logic [4:1] c_o,
  output logic       grp_g_o,
  output logic       grp_p_o
);

  // Flattened lookahead equations, no ripple between bits
  always_comb begin
    c_o[1] = g_i[0] | (p_i[0] & cin_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    c_o[4] = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
           | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & cin_i);
    grp_g_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
            | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    grp_p_o = &p_i;
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential wide adder: one CLA slice reused over WIDTH/4 clocks, one nibble
// per clock. Result is held after done until the next accepted request.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  cla_seq_adder_if.slave bus
);

  localparam int unsigned NumNib = WIDTH / NIBBLE;
  localparam int unsigned IdxW   = idx_width(WIDTH);
  localparam int unsigned ShW    = IdxW + 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IdxW-1:0]  idx_q, idx_d;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [ShW-1:0]   shamt;
  logic [3:0]       g, p, nib_sum;
  logic [4:1]       c;
  logic             grp_g, grp_p;
  logic [WIDTH-1:0] nib_mask, nib_bits;
  logic             last;

  assign shamt    = {idx_q, 2'b00};
  assign g        = a_q[shamt +: NIBBLE] & b_q[shamt +: NIBBLE];
  assign p        = a_q[shamt +: NIBBLE] ^ b_q[shamt +: NIBBLE];
  assign nib_sum  = p ^ {c[3:1], carry_q};
  assign nib_mask = WIDTH'(4'hF) << shamt;
  assign nib_bits = WIDTH'(nib_sum) << shamt;
  assign last     = (idx_q == LastIdx);

  cla4_slice u_slice (
    .g_i     (g),
    .p_i     (p),
    .cin_i   (carry_q),
    .c_o     (c),
    .grp_g_o (grp_g),
    .grp_p_o (grp_p)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath next values
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d   = (sum_q & ~nib_mask) | nib_bits;
        // Group terms give the same value as c[4]
        carry_d = grp_g | (grp_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (last) begin
          cout_d  = c[4];
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = c[3] ^ c[4];
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: the driver pushes the arithmetic result
// of each request, a monitor pops and compares whenever done is seen.
module tb_cla_seq_adder;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_seq_adder_if #(.WIDTH(W)) bus ();

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: {cout,sum} = a+b+cin, signed overflow from operand signs
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    exp_t e;
    t      = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Monitor: compare every presented result against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sum", bus.sum, e.sum);
        chk("cout", bus.cout, e.cout);
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", bus.ovf, e.ovf);
`endif
      end
    end
  end

  // Issue one request at the current negedge and follow its timing; returns at
  // the negedge of the done cycle so the caller may issue back-to-back.
  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input bit poke);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    sb.push_back(model(a, b, c));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    for (int k = 1; k <= N; k++) begin
      chk("busy_run", bus.busy, 1);
      chk("done_early", bus.done, 0);
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.a     = '1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_latency", bus.done, 1);
    chk("busy_done", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    add(16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("t1_sum", bus.sum, 16'h5555);
    @(negedge clk);
    chk("hold_sum", bus.sum, 16'h5555);
    chk("hold_done_low", bus.done, 0);

    add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t2_sum", bus.sum, 16'h0000);
    chk("t2_cout", bus.cout, 1);
    @(negedge clk);

    add(16'h000F, 16'h0001, 1'b1, 1'b0);
    chk("t3_sum", bus.sum, 16'h0011);
    add(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("b2b_sum", bus.sum, 16'h0002);
    @(negedge clk);

    add(16'h1111, 16'h2222, 1'b0, 1'b1);
    chk("ignore_start_sum", bus.sum, 16'h3333);
    @(negedge clk);
    chk("ignore_start_idle", bus.busy, 0);

    add(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("t5_sum", bus.sum, 16'h8000);
    chk("t5_cout", bus.cout, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("t5_ovf", bus.ovf, 1);
`endif
    add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
`ifdef CLA_SEQ_OVF_EN
    chk("t6_ovf", bus.ovf, 0);
`endif
    @(negedge clk);

    // Reset two cycles into RUN abandons the request
    bus.start = 1'b1;
    bus.a     = 16'hABCD;
    bus.b     = 16'h1357;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_cout", bus.cout, 0);
    rst = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      chk("midrst_no_done", bus.done, 0);
    end

    for (int i = 0; i < 40; i++) begin
      add(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
